// File: rtl/recip_sig_iter_if.sv
// recip_sig_iter_if: operand/result handshake bundle for the reciprocal
// significand stage. The master side drives operands and accepts results;
// the slave side is the divider itself.
interface recip_sig_iter_if #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 23
) ();

  // Operand side
  logic                   inValid;
  logic                   inReady;
  logic                   negIn;
  logic signed [NEXP+1:0] expIn;
  logic [NSIG:0]          sigIn;

  // Result side
  logic                   outValid;
  logic                   outReady;
  logic                   negOut;
  logic signed [NEXP+1:0] expOut;
  logic [INTn-1:0]        sigOut;
  logic                   divByZero;

  modport master (
    output inValid, negIn, expIn, sigIn, outReady,
    input  inReady, outValid, negOut, expOut, sigOut, divByZero
  );

  modport slave (
    input  inValid, negIn, expIn, sigIn, outReady,
    output inReady, outValid, negOut, expOut, sigOut, divByZero
  );

endinterface

// File: rtl/recip_sig_iter.sv
// recip_sig_iter: iterative restoring divider producing 1/sig for a
// normalized significand, one quotient bit per clock. The result is an
// unrounded INTn-bit significand (sticky folded into its LSB), the negated
// and normalization-adjusted exponent, and the sign.
// Optional feature macro: RECIP_EARLY_TERM_EN -- leave DIV as soon as the
// remainder reaches zero (remaining quotient bits are already zero).
module recip_sig_iter #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 23
) (
  input  logic           clk,
  input  logic           rst_n,
  recip_sig_iter_if.slave bus
);

  localparam int EW    = NEXP + 2;
  localparam int RW    = NSIG + 2;
  localparam int QW    = INTn + 1;
  localparam int CNT_W = $clog2(INTn + 1);

  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

`ifdef RECIP_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Division working registers
  logic [RW-1:0]          r_rem;
  logic [NSIG:0]          r_div;
  logic [QW-1:0]          r_q;
  logic [CNT_W-1:0]       r_cnt;

  // Captured operand fields
  logic                   r_neg;
  logic                   r_zero;
  logic signed [EW-1:0]   r_exp;

  // Result registers, frozen while outValid is high
  logic                   r_out_valid;
  logic                   r_neg_out;
  logic                   r_dbz;
  logic signed [EW-1:0]   r_exp_out;
  logic [INTn-1:0]        r_sig_out;

  logic                   w_accept;
  logic                   w_in_ready;
  logic                   w_load_out;
  logic                   w_handoff;
  logic                   w_ge;
  logic                   w_last;
  logic                   w_rem_zero;
  logic [RW-1:0]          w_diff;
  logic [RW-1:0]          w_rem_nxt;
  logic [CNT_W-1:0]       w_qidx;
  logic [INTn-1:0]        w_sig_norm;
  logic signed [EW-1:0]   w_exp_norm;
  logic                   w_sticky;

  assign w_accept   = (r_state == S_IDLE) && bus.inValid;
  assign w_load_out = (r_state == S_DONE) && !r_out_valid;
  assign w_handoff  = (r_state == S_DONE) && r_out_valid && bus.outReady;

  // One restoring step: subtract when it fits, then double the remainder.
  // The partial remainder stays below 2*D, so the shift never drops a bit.
  assign w_ge       = (r_rem >= {1'b0, r_div});
  assign w_diff     = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
  assign w_rem_nxt  = {w_diff[RW-2:0], 1'b0};
  // Quotient bit i (weight 2^-i) lives at r_q[INTn-i], so r_q[INTn] is q0
  assign w_qidx     = CNT_W'(INTn) - r_cnt;
  assign w_last     = (r_cnt == CNT_W'(INTn));
  assign w_rem_zero = (r_rem == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.inValid) begin
          w_state_nxt = (bus.sigIn == '0) ? S_DONE : S_DIV;
        end
      end
      S_DIV: begin
        if (w_last || (EARLY_TERM && w_rem_zero)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_handoff) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    w_in_ready = (r_state == S_IDLE);
  end

  // Operand capture and one quotient bit per DIV cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_neg  <= 1'b0;
      r_zero <= 1'b0;
      r_exp  <= '0;
    end else if (w_accept) begin
      r_rem  <= RW'(1) << NSIG;
      r_div  <= bus.sigIn;
      r_q    <= '0;
      r_cnt  <= '0;
      r_neg  <= bus.negIn;
      r_zero <= (bus.sigIn == '0);
      r_exp  <= bus.expIn;
    end else if (r_state == S_DIV) begin
      r_q[w_qidx] <= w_ge;
      r_rem       <= w_rem_nxt;
      r_cnt       <= r_cnt + 1'b1;
    end
  end

  // Normalize the quotient: only 1.0 yields q0=1; otherwise the leading
  // one is q1 and the exponent drops by one. Sticky folds into the LSB.
  always_comb begin
    w_sig_norm = '0;
    w_exp_norm = -r_exp;
    w_sticky   = 1'b0;
    if (!r_zero) begin
      if (r_q[INTn]) begin
        w_sig_norm = r_q[INTn:1];
        w_sticky   = r_q[0] | !w_rem_zero;
      end else begin
        w_sig_norm = r_q[INTn-1:0];
        w_sticky   = !w_rem_zero;
        w_exp_norm = -r_exp - EXP_ONE;
      end
    end
    w_sig_norm[0] = w_sig_norm[0] | w_sticky;
  end

  // Result registers: load on entry to DONE, release on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_neg_out   <= 1'b0;
      r_dbz       <= 1'b0;
      r_exp_out   <= '0;
      r_sig_out   <= '0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_neg_out   <= r_neg;
      r_dbz       <= r_zero;
      r_exp_out   <= w_exp_norm;
      r_sig_out   <= w_sig_norm;
    end else if (w_handoff) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.inReady   = w_in_ready;
  assign bus.outValid  = r_out_valid;
  assign bus.negOut    = r_neg_out;
  assign bus.expOut    = r_exp_out;
  assign bus.sigOut    = r_sig_out;
  assign bus.divByZero = r_dbz;

endmodule

// File: tb/tb_recip_sig_iter.sv
// tb_recip_sig_iter: randomized bench for recip_sig_iter with an arithmetic
// reference model (integer division of 2^(INTn+NSIG) by the significand).
module tb_recip_sig_iter;

  localparam int INTn = 32;
  localparam int NEXP = 8;
  localparam int NSIG = 23;

`ifdef RECIP_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  recip_sig_iter_if #(.INTn(INTn), .NEXP(NEXP), .NSIG(NSIG)) ifc ();

  recip_sig_iter #(.INTn(INTn), .NEXP(NEXP), .NSIG(NSIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Expected result of the operand currently in flight
  logic [31:0]        e_sig = '0;
  logic signed [9:0]  e_exp = '0;
  logic               e_neg = 1'b0;
  logic               e_dbz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // 1/s with s = sig/2^NSIG: quotient bits q0..qINTn form floor(2^(INTn+NSIG)/sig)
  function automatic void model(input logic [23:0] sig, input logic signed [9:0] e,
                                output logic [31:0] so, output logic signed [9:0] eo,
                                output logic dbz);
    longint unsigned n, q, r;
    logic st;
    dbz = (sig == 24'd0);
    so  = '0;
    eo  = -e;
    if (sig != 24'd0) begin
      n = 64'd1 << (INTn + NSIG);
      q = n / 64'(sig);
      r = n % 64'(sig);
      if (q[32]) begin
        so = q[32:1];
        st = q[0] | (r != 0);
      end else begin
        so = q[31:0];
        st = (r != 0);
        eo = -e - 10'sd1;
      end
      so[0] = so[0] | st;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle a result is presented it must match the model and the
  // block must refuse new operands.
  always @(negedge clk) begin
    if (rst_n && ifc.outValid) begin
      check("sigOut",    64'(ifc.sigOut),    64'(e_sig));
      check("expOut",    64'(ifc.expOut),    64'(e_exp));
      check("negOut",    64'(ifc.negOut),    64'(e_neg));
      check("divByZero", 64'(ifc.divByZero), 64'(e_dbz));
      check("inReady_busy", 64'(ifc.inReady), 64'd0);
    end
  end

  task automatic do_op(input logic neg, input logic signed [9:0] e, input logic [23:0] sig,
                       input int hold, input bit poke);
    int lat;
    int exp_lat;
    logic [31:0] ms;
    logic signed [9:0] me;
    logic md;
    model(sig, e, ms, me, md);
    for (int i = 0; i < 200 && !ifc.inReady; i++) tick();
    check("inReady_idle", 64'(ifc.inReady), 64'd1);
    ifc.negIn   = neg;
    ifc.expIn   = e;
    ifc.sigIn   = sig;
    ifc.inValid = 1'b1;
    e_sig = ms;
    e_exp = me;
    e_neg = neg;
    e_dbz = md;
    if (sig == 24'd0)                   exp_lat = 1;
    else if (EARLY && sig == 24'h800000) exp_lat = 3;
    else                                exp_lat = INTn + 2;
    tick();
    ifc.inValid = 1'b0;
    ifc.sigIn   = 24'($urandom);
    ifc.expIn   = 10'($urandom);
    ifc.negIn   = 1'($urandom);
    lat = 0;
    while (!ifc.outValid && lat < 100) begin
      ifc.outReady = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    ifc.outReady = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        ifc.inValid = 1'b1;
        ifc.sigIn   = 24'($urandom) | 24'h800000;
        ifc.expIn   = 10'($urandom_range(0, 100));
      end
      tick();
    end
    ifc.inValid  = 1'b0;
    ifc.outReady = 1'b1;
    tick();
    ifc.outReady = 1'b0;
    check("outValid_drop", 64'(ifc.outValid), 64'd0);
    check("inReady_back",  64'(ifc.inReady),  64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inReady"},   64'(ifc.inReady),   64'd1);
    check({tag, "_outValid"},  64'(ifc.outValid),  64'd0);
    check({tag, "_sigOut"},    64'(ifc.sigOut),    64'd0);
    check({tag, "_expOut"},    64'(ifc.expOut),    64'd0);
    check({tag, "_negOut"},    64'(ifc.negOut),    64'd0);
    check({tag, "_divByZero"}, 64'(ifc.divByZero), 64'd0);
  endtask

  initial begin
    logic [31:0] ms;
    logic signed [9:0] me;
    logic md;
    logic [23:0] rs;
    int ei;

    ifc.inValid  = 1'b0;
    ifc.negIn    = 1'b0;
    ifc.expIn    = '0;
    ifc.sigIn    = '0;
    ifc.outReady = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Hand-computed anchors for the model
    model(24'h800000, 10'sd0, ms, me, md);
    check("model_1p0_sig", 64'(ms), 64'h80000000);
    check("model_1p0_exp", 64'(me), 64'(10'sd0));
    model(24'hC00000, 10'sd3, ms, me, md);
    check("model_1p5_sig", 64'(ms), 64'hAAAAAAAB);
    check("model_1p5_exp", 64'(me), 64'(-10'sd4));
    model(24'hFFFFFF, 10'sd0, ms, me, md);
    check("model_max_sig", 64'(ms), 64'h80000081);
    check("model_max_exp", 64'(me), 64'(-10'sd1));
    model(24'h000000, 10'sd5, ms, me, md);
    check("model_zero_dbz", 64'(md), 64'd1);
    check("model_zero_exp", 64'(me), 64'(-10'sd5));

    tick();
    do_op(1'b0, 10'sd0,  24'h800000, 2, 1'b0);
    do_op(1'b1, 10'sd3,  24'hC00000, 1, 1'b0);
    do_op(1'b0, 10'sd0,  24'hFFFFFF, 0, 1'b0);
    do_op(1'b0, 10'sd5,  24'h000000, 1, 1'b0);
    do_op(1'b1, -10'sd7, 24'hA5A5A5, 10, 1'b1);
    do_op(1'b0, 10'sd12, 24'h9ABCDE, 0, 1'b0);

    // Reset in the middle of a division
    ifc.negIn   = 1'b1;
    ifc.expIn   = 10'sd9;
    ifc.sigIn   = 24'hD00001;
    ifc.inValid = 1'b1;
    tick();
    ifc.inValid = 1'b0;
    repeat (10) tick();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    do_op(1'b1, 10'sd9, 24'hD00001, 1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 9))
        0:       rs = 24'h000000;
        1:       rs = 24'h800000;
        default: rs = 24'($urandom) | 24'h800000;
      endcase
      ei = int'($urandom_range(0, 254)) - 127;
      do_op(1'($urandom), 10'(ei), rs, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
